// File: rtl/or1200_immu_top.sv
`default_nettype none
// ============================================================================
// Module   : or1200_immu_top
// Brief    : OR1200 instruction MMU with a 64-set direct-mapped ITLB, 8 KB pages.
// Revision : 1.0
// ============================================================================
module or1200_immu_top #(
    parameter int aw = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ic_en,
    input  logic          immu_en,
    input  logic          supv,
    input  logic [aw-1:0] icpu_adr_i,
    input  logic          icpu_cycstb_i,
    output logic [aw-1:0] icpu_adr_o,
    output logic [3:0]    icpu_tag_o,
    output logic          icpu_rty_o,
    output logic          icpu_err_o,
    input  logic          boot_adr_sel_i,
    input  logic          spr_cs,
    input  logic          spr_write,
    input  logic [31:0]   spr_addr,
    input  logic [31:0]   spr_dat_i,
    output logic [31:0]   spr_dat_o,
    input  logic          qmemimmu_rty_i,
    input  logic          qmemimmu_err_i,
    input  logic [3:0]    qmemimmu_tag_i,
    output logic [aw-1:0] qmemimmu_adr_o,
    output logic          qmemimmu_cycstb_o,
    output logic          qmemimmu_ci_o
);

    localparam int        PW       = aw - 13;
    localparam logic [3:0] TAG_MISS  = 4'hA;
    localparam logic [3:0] TAG_FAULT = 4'hB;

    logic [PW-1:0] vpn_q [64];
    logic [PW-1:0] ppn_q [64];
    logic [63:0]   v_q;
    logic [63:0]   uxe_q;
    logic [63:0]   sxe_q;
    logic [63:0]   ci_q;
    logic [aw-1:0] adr_q;
    logic [aw-1:0] adr_d;

    logic [5:0]    w_set;
    logic [5:0]    w_spr_idx;
    logic          w_xlate;
    logic          w_hit;
    logic          w_exe;
    logic          w_miss;
    logic          w_fault;
    logic [31:0]   w_spr_rd;
    logic          w_unused;

    assign w_set     = icpu_adr_i[18:13];
    assign w_spr_idx = spr_addr[5:0];
    assign w_unused  = ^{spr_addr[31:8], spr_addr[6], spr_dat_i[12:8], spr_dat_i[5:2]};

    // ITLB arrays; the reset branch also masks SPR writes while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                vpn_q[i] <= '0;
                ppn_q[i] <= '0;
            end
            v_q   <= '0;
            uxe_q <= '0;
            sxe_q <= '0;
            ci_q  <= '0;
        end else if (spr_cs && spr_write) begin
            if (!spr_addr[7]) begin
                vpn_q[w_spr_idx] <= spr_dat_i[aw-1:13];
                v_q[w_spr_idx]   <= spr_dat_i[0];
            end else begin
                ppn_q[w_spr_idx] <= spr_dat_i[aw-1:13];
                uxe_q[w_spr_idx] <= spr_dat_i[7];
                sxe_q[w_spr_idx] <= spr_dat_i[6];
                ci_q[w_spr_idx]  <= spr_dat_i[1];
            end
        end
    end

    always_comb begin
        w_spr_rd = '0;
        if (spr_cs && !spr_write) begin
            if (!spr_addr[7]) begin
                w_spr_rd[aw-1:13] = vpn_q[w_spr_idx];
                w_spr_rd[0]       = v_q[w_spr_idx];
            end else begin
                w_spr_rd[aw-1:13] = ppn_q[w_spr_idx];
                w_spr_rd[7]       = uxe_q[w_spr_idx];
                w_spr_rd[6]       = sxe_q[w_spr_idx];
                w_spr_rd[1]       = ci_q[w_spr_idx];
            end
        end
    end

    assign spr_dat_o = w_spr_rd;

    // Only VPN[31:19] is compared: bits [18:13] are implied by the set index
    assign w_xlate = immu_en && !boot_adr_sel_i;
    assign w_hit   = v_q[w_set] && (vpn_q[w_set][PW-1:6] == icpu_adr_i[aw-1:19]);
    assign w_exe   = supv ? sxe_q[w_set] : uxe_q[w_set];
    assign w_miss  = w_xlate && !w_hit;
    assign w_fault = w_xlate && w_hit && !w_exe;

    always_comb begin
        if (w_xlate) begin
            qmemimmu_adr_o = {ppn_q[w_set], icpu_adr_i[12:0]};
            qmemimmu_ci_o  = ci_q[w_set] | ~ic_en;
        end else begin
            qmemimmu_adr_o = icpu_adr_i;
            qmemimmu_ci_o  = boot_adr_sel_i | ~ic_en;
        end
    end

    always_comb begin
        qmemimmu_cycstb_o = icpu_cycstb_i;
        icpu_rty_o        = qmemimmu_rty_i;
        icpu_err_o        = qmemimmu_err_i;
        icpu_tag_o        = qmemimmu_tag_i;
        if (w_miss || w_fault) begin
            qmemimmu_cycstb_o = 1'b0;
            icpu_rty_o        = 1'b0;
            icpu_err_o        = 1'b1;
            icpu_tag_o        = w_miss ? TAG_MISS : TAG_FAULT;
        end
    end

    assign adr_d = (icpu_cycstb_i && !qmemimmu_rty_i) ? qmemimmu_adr_o : adr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adr_q <= '0;
        end else begin
            adr_q <= adr_d;
        end
    end

    assign icpu_adr_o = adr_q;

endmodule
`default_nettype wire

// File: tb/tb_or1200_immu_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_or1200_immu_top
// Brief    : Randomized self-checking bench for or1200_immu_top.
// Revision : 1.0
// ============================================================================
module tb_or1200_immu_top;

    logic        clk;
    logic        rst;
    logic        ic_en, immu_en, supv;
    logic [31:0] icpu_adr_i;
    logic        icpu_cycstb_i;
    logic [31:0] icpu_adr_o;
    logic [3:0]  icpu_tag_o;
    logic        icpu_rty_o, icpu_err_o;
    logic        boot_adr_sel_i;
    logic        spr_cs, spr_write;
    logic [31:0] spr_addr, spr_dat_i, spr_dat_o;
    logic        qmemimmu_rty_i, qmemimmu_err_i;
    logic [3:0]  qmemimmu_tag_i;
    logic [31:0] qmemimmu_adr_o;
    logic        qmemimmu_cycstb_o, qmemimmu_ci_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic run = 1'b0;

    or1200_immu_top #(.aw(32)) dut (
        .clk(clk), .rst(rst), .ic_en(ic_en), .immu_en(immu_en), .supv(supv),
        .icpu_adr_i(icpu_adr_i), .icpu_cycstb_i(icpu_cycstb_i), .icpu_adr_o(icpu_adr_o),
        .icpu_tag_o(icpu_tag_o), .icpu_rty_o(icpu_rty_o), .icpu_err_o(icpu_err_o),
        .boot_adr_sel_i(boot_adr_sel_i), .spr_cs(spr_cs), .spr_write(spr_write),
        .spr_addr(spr_addr), .spr_dat_i(spr_dat_i), .spr_dat_o(spr_dat_o),
        .qmemimmu_rty_i(qmemimmu_rty_i), .qmemimmu_err_i(qmemimmu_err_i),
        .qmemimmu_tag_i(qmemimmu_tag_i), .qmemimmu_adr_o(qmemimmu_adr_o),
        .qmemimmu_cycstb_o(qmemimmu_cycstb_o), .qmemimmu_ci_o(qmemimmu_ci_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each ITLB register is kept as the 32-bit word it reads back as
    logic [31:0] mt [64];
    logic [31:0] tr [64];
    logic [31:0] exp_adr;
    logic        adr_known;

    logic [31:0] m_w, t_w, e_padr, e_spr;
    logic        e_xl, e_hit, e_miss, e_fault, e_ci, e_cyc, e_rty, e_err;
    logic [3:0]  e_tag;

    always_comb begin
        m_w     = mt[icpu_adr_i[18:13]];
        t_w     = tr[icpu_adr_i[18:13]];
        e_xl    = immu_en && !boot_adr_sel_i;
        e_hit   = m_w[0] && (m_w[31:19] == icpu_adr_i[31:19]);
        e_miss  = e_xl && !e_hit;
        e_fault = e_xl && e_hit && !(supv ? t_w[6] : t_w[7]);
        e_padr  = e_xl ? ((t_w & 32'hFFFFE000) | (icpu_adr_i & 32'h00001FFF)) : icpu_adr_i;
        e_ci    = e_xl ? (t_w[1] || !ic_en) : (boot_adr_sel_i || !ic_en);
        e_cyc   = icpu_cycstb_i;
        e_rty   = qmemimmu_rty_i;
        e_err   = qmemimmu_err_i;
        e_tag   = qmemimmu_tag_i;
        if (e_miss || e_fault) begin
            e_cyc = 1'b0;
            e_rty = 1'b0;
            e_err = 1'b1;
            e_tag = e_miss ? 4'hA : 4'hB;
        end
        e_spr = 32'h0;
        if (spr_cs && !spr_write)
            e_spr = spr_addr[7] ? tr[spr_addr[5:0]] : mt[spr_addr[5:0]];
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                mt[i] <= 32'h0;
                tr[i] <= 32'h0;
            end
            exp_adr   <= 32'h0;
            adr_known <= 1'b1;
        end else begin
            if (spr_cs && spr_write) begin
                if (spr_addr[7]) tr[spr_addr[5:0]] <= spr_dat_i & 32'hFFFFE0C2;
                else             mt[spr_addr[5:0]] <= spr_dat_i & 32'hFFFFE001;
            end
            if (icpu_cycstb_i && !qmemimmu_rty_i) begin
                exp_adr   <= e_padr;
                adr_known <= !e_miss;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("cycstb", {31'b0, qmemimmu_cycstb_o}, {31'b0, e_cyc});
            chk("rty",    {31'b0, icpu_rty_o},        {31'b0, e_rty});
            chk("err",    {31'b0, icpu_err_o},        {31'b0, e_err});
            chk("tag",    {28'b0, icpu_tag_o},        {28'b0, e_tag});
            chk("spr_rd", spr_dat_o, e_spr);
            if (!e_miss) begin
                chk("qadr", qmemimmu_adr_o, e_padr);
                chk("ci",   {31'b0, qmemimmu_ci_o}, {31'b0, e_ci});
            end
            if (adr_known) chk("icpu_adr", icpu_adr_o, exp_adr);
        end
    end

    task automatic rand_cycle();
        logic [31:0] a;
        logic [5:0]  idx;
        spr_cs    = ($urandom_range(0, 3) == 0);
        spr_write = $urandom_range(0, 1) == 1;
        a         = $urandom;
        if ($urandom_range(0, 7) != 0) a[5:3] = 3'b000;
        spr_addr  = a;
        a         = $urandom;
        if (!spr_addr[7]) a[0] = ($urandom_range(0, 3) != 0);
        spr_dat_i = a;
        immu_en        = ($urandom_range(0, 3) != 0);
        boot_adr_sel_i = ($urandom_range(0, 9) == 0);
        ic_en          = $urandom_range(0, 1) == 1;
        supv           = $urandom_range(0, 1) == 1;
        icpu_cycstb_i  = $urandom_range(0, 1) == 1;
        qmemimmu_rty_i = ($urandom_range(0, 4) == 0);
        qmemimmu_err_i = ($urandom_range(0, 4) == 0);
        qmemimmu_tag_i = 4'($urandom);
        idx = ($urandom_range(0, 7) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
        a = $urandom;
        a[18:13] = idx;
        if ($urandom_range(0, 9) < 7) a[31:19] = mt[idx][31:19];
        icpu_adr_i = a;
    endtask

    initial begin
        rst = 1'b1;
        ic_en = 1'b0; immu_en = 1'b0; supv = 1'b0; boot_adr_sel_i = 1'b0;
        icpu_adr_i = 32'h0; icpu_cycstb_i = 1'b0;
        spr_cs = 1'b0; spr_write = 1'b0; spr_addr = 32'h0; spr_dat_i = 32'h0;
        qmemimmu_rty_i = 1'b0; qmemimmu_err_i = 1'b0; qmemimmu_tag_i = 4'h0;
        #1 rst = 1'b0;
        immu_en = 1'b1; icpu_adr_i = 32'd13; icpu_cycstb_i = 1'b1;
        spr_cs = 1'b1; spr_write = 1'b1; spr_addr = 32'd10; spr_dat_i = 32'hFFFFFFFF;
        run = 1'b1;
        #2;
        chk("rst_err",    {31'b0, icpu_err_o}, 32'd1);
        chk("rst_tag",    {28'b0, icpu_tag_o}, 32'hA);
        chk("rst_cycstb", {31'b0, qmemimmu_cycstb_o}, 32'd0);
        chk("rst_adr",    icpu_adr_o, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; spr_write = 1'b0; immu_en = 1'b0; icpu_cycstb_i = 1'b0;
        #1 chk("rst_wr_ignored", spr_dat_o, 32'h0);
        @(posedge clk); #1 spr_write = 1'b1; spr_dat_i = 32'hACAC01F1;
        @(posedge clk); #1 spr_write = 1'b0;
        #1 chk("match_rd", spr_dat_o, 32'hACAC0001);
        @(posedge clk); #1 spr_addr = 32'h8A; spr_write = 1'b1; spr_dat_i = 32'h000020C2;
        @(posedge clk); #1 spr_write = 1'b0;
        #1 chk("xlat_rd", spr_dat_o, 32'h000020C2);
        @(posedge clk); #1 spr_cs = 1'b0; immu_en = 1'b1; supv = 1'b1; icpu_cycstb_i = 1'b1;
        icpu_adr_i = 32'hACA94004; ic_en = 1'b1;
        #1 chk("hit_qadr", qmemimmu_adr_o, 32'h00002004);
        chk("hit_ci",  {31'b0, qmemimmu_ci_o}, 32'd1);
        chk("hit_err", {31'b0, icpu_err_o}, 32'd0);
        @(posedge clk); #1 chk("hit_adr_o", icpu_adr_o, 32'h00002004);
        spr_cs = 1'b1; spr_write = 1'b1; spr_addr = 32'h8A; spr_dat_i = 32'h00002040; supv = 1'b0;
        @(posedge clk); #1 spr_cs = 1'b0; spr_write = 1'b0;
        #1 chk("pf_err", {31'b0, icpu_err_o}, 32'd1);
        chk("pf_tag",    {28'b0, icpu_tag_o}, 32'hB);
        chk("pf_cycstb", {31'b0, qmemimmu_cycstb_o}, 32'd0);
        @(posedge clk); #1 immu_en = 1'b0; ic_en = 1'b1; icpu_adr_i = 32'd2; qmemimmu_rty_i = 1'b1;
        #1 chk("byp_qadr", qmemimmu_adr_o, 32'd2);
        chk("byp_rty", {31'b0, icpu_rty_o}, 32'd1);
        chk("byp_ci",  {31'b0, qmemimmu_ci_o}, 32'd0);
        @(posedge clk); #1 chk("byp_adr_hold", icpu_adr_o, 32'h00002004);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rand_cycle();
            if (c == 1500) begin
                #2 rst = 1'b0;
                #1 rst = 1'b1;
            end
        end
        @(posedge clk); #1 run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
